// File: rtl/mon_tx_arbiter.sv
// rtl/mon_tx_arbiter.sv - arbitrates packet sources onto the single monitor-link packet sender
module mon_tx_arbiter #(
   parameter int NUM_REQ       = 3,
   parameter int PKT_W         = 40,
   parameter int GAP_CYCLES    = 4,
   parameter int START_TIMEOUT = 8,
   parameter int URGENT0       = 1
) (
   input  logic                     mon_clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*PKT_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ack,
   output logic [PKT_W-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     sender_busy,
   output logic [1:0]               grant_id,
   output logic                     timeout_err
);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_LAUNCH     = 3'd1;
   localparam logic [2:0] ST_WAIT_START = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
   localparam logic [2:0] ST_GAP        = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [3:0]         tcnt_q, tcnt_d;
   logic [3:0]         gcnt_q, gcnt_d;
   logic [1:0]         rr_ptr_q, rr_ptr_d;
   logic [1:0]         grant_q, grant_d;
   logic [PKT_W-1:0]   data_q, data_d;
   logic               valid_q, valid_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               terr_q, terr_d;

   logic [1:0]         win;
   logic               found;
   logic [PKT_W-1:0]   win_data;
   logic [1:0]         grant_nxt;

   // Winner: first pending requester at or above rr_ptr, then wrap to the bottom; urgent source 0 overrides
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i] && (2'(i) >= rr_ptr_q)) begin
            win   = 2'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i]) begin
            win   = 2'(i);
            found = 1'b1;
         end
      end
      if ((URGENT0 != 0) && req_valid[0]) begin
         win = '0;
      end
   end

   // Packet mux for the selected requester
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == 2'(i)) begin
            win_data = req_data[i*PKT_W +: PKT_W];
         end
      end
   end

   assign grant_nxt = (grant_q == 2'(NUM_REQ-1)) ? 2'd0 : grant_q + 2'd1;

   // Launch/handshake sequencing; out_valid and req_ack are registered single-cycle pulses
   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      gcnt_d   = gcnt_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      ack_d    = '0;
      terr_d   = terr_q;
      case (state_q)
         ST_IDLE: begin
            // busy seen here belongs to someone else: hold off until the sender is free
            if ((|req_valid) && !sender_busy) begin
               data_d  = win_data;
               grant_d = win;
               valid_d = 1'b1;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            tcnt_d  = '0;
            state_d = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (sender_busy) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  ack_d[i] = (grant_q == 2'(i));
               end
               state_d = ST_WAIT_DONE;
            end else if (tcnt_q == 4'(START_TIMEOUT-1)) begin
               // no ack and no rr_ptr advance, so the same requester is retried
               terr_d  = 1'b1;
               gcnt_d  = '0;
               state_d = ST_GAP;
            end else begin
               tcnt_d = tcnt_q + 4'd1;
            end
         end
         ST_WAIT_DONE: begin
            if (!sender_busy) begin
               rr_ptr_d = grant_nxt;
               gcnt_d   = '0;
               state_d  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gcnt_q == 4'(GAP_CYCLES-1)) begin
               state_d = ST_IDLE;
            end else begin
               gcnt_d = gcnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any transfer without an ack
   always_ff @(posedge mon_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         tcnt_q   <= '0;
         gcnt_q   <= '0;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ack_q    <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         gcnt_q   <= gcnt_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ack_q    <= ack_d;
         terr_q   <= terr_d;
      end
   end

   assign out_data    = data_q;
   assign out_valid   = valid_q;
   assign req_ack     = ack_q;
   assign grant_id    = grant_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_mon_tx_arbiter.sv
// tb/tb_mon_tx_arbiter.sv - scoreboard bench for mon_tx_arbiter (round-robin and urgent instances)
module tb_mon_tx_arbiter;

   localparam int GAP = 4;
   localparam int TMO = 8;
   localparam logic [39:0] D0 = 40'hA0_1111_0000;
   localparam logic [39:0] D1 = 40'hC1_0000_1234;
   localparam logic [39:0] D2 = 40'h5E_DEAD_BEEF;

   logic         mon_clk;
   logic         rst_n       [2];
   logic [2:0]   req_valid   [2];
   logic [119:0] req_data;
   logic [2:0]   req_ack     [2];
   logic [39:0]  out_data    [2];
   logic         out_valid   [2];
   logic         busy_m      [2];
   logic         busy_f      [2];
   logic         sen_en      [2];
   logic [1:0]   grant_id    [2];
   logic         timeout_err [2];

   int cyc;
   int errors;
   int checks;

   logic [41:0] lq [2][32];
   int          lwr [2];
   int          lrd [2];
   logic [2:0]  aq [2][32];
   int          awr [2];
   int          ard [2];
   int          launch_cyc [2];
   int          fall_cyc [2];
   logic        fall_ok [2];

   mon_tx_arbiter #(.URGENT0(0)) dut_rr (
      .mon_clk     (mon_clk),
      .rst_n       (rst_n[0]),
      .req_valid   (req_valid[0]),
      .req_data    (req_data),
      .req_ack     (req_ack[0]),
      .out_data    (out_data[0]),
      .out_valid   (out_valid[0]),
      .sender_busy (busy_m[0] | busy_f[0]),
      .grant_id    (grant_id[0]),
      .timeout_err (timeout_err[0])
   );

   mon_tx_arbiter #(.URGENT0(1)) dut_urg (
      .mon_clk     (mon_clk),
      .rst_n       (rst_n[1]),
      .req_valid   (req_valid[1]),
      .req_data    (req_data),
      .req_ack     (req_ack[1]),
      .out_data    (out_data[1]),
      .out_valid   (out_valid[1]),
      .sender_busy (busy_m[1] | busy_f[1]),
      .grant_id    (grant_id[1]),
      .timeout_err (timeout_err[1])
   );

   initial begin
      mon_clk = 1'b0;
      forever #5 mon_clk = ~mon_clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge mon_clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_l(input int g, input logic [1:0] id, input logic [39:0] d);
      lq[g][lwr[g]] = {id, d};
      lwr[g]++;
   endtask

   task automatic push_a(input int g, input logic [2:0] a);
      aq[g][awr[g]] = a;
      awr[g]++;
   endtask

   task automatic check_reset(input int g);
      chk("rst_out_valid", 64'(out_valid[g]), 64'd0);
      chk("rst_out_data", 64'(out_data[g]), 64'd0);
      chk("rst_req_ack", 64'(req_ack[g]), 64'd0);
      chk("rst_grant_id", 64'(grant_id[g]), 64'd0);
      chk("rst_timeout_err", 64'(timeout_err[g]), 64'd0);
   endtask

   // Called at posedge+1 right after the request is driven
   task automatic expect_launch_next(input int g, input string name);
      @(posedge mon_clk);
      @(negedge mon_clk);
      chk(name, 64'(out_valid[g]), 64'd1);
   endtask

   task automatic wait_acks(input int g, input int target);
      int n;
      n = 0;
      while (ard[g] < target && n < 400) begin
         @(negedge mon_clk);
         n++;
      end
      chk("ack_wait", 64'(ard[g] >= target), 64'd1);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      // Sender model: busy rises 2 cycles after the launch pulse and stays 20 cycles
      initial begin : sender
         forever begin
            @(negedge mon_clk);
            if (out_valid[g] && sen_en[g]) begin
               repeat (2) @(posedge mon_clk);
               #1 busy_m[g] = 1'b1;
               repeat (20) @(posedge mon_clk);
               #1 busy_m[g] = 1'b0;
               fall_cyc[g] = cyc;
               fall_ok[g]  = 1'b1;
            end
         end
      end

      initial begin : monitor
         forever begin
            @(negedge mon_clk);
            if (out_valid[g]) begin
               checks++;
               if (lrd[g] >= lwr[g]) begin
                  errors++;
                  $display("FAIL launch_unexpected[%0d]: got grant=%0d data=%h, required no launch", g, grant_id[g], out_data[g]);
               end else begin
                  if ({grant_id[g], out_data[g]} !== lq[g][lrd[g]]) begin
                     errors++;
                     $display("FAIL launch[%0d]#%0d: got grant=%0d data=%h, required grant=%0d data=%h", g, lrd[g], grant_id[g], out_data[g], lq[g][lrd[g]][41:40], lq[g][lrd[g]][39:0]);
                  end
                  lrd[g]++;
               end
               launch_cyc[g] = cyc;
               if (fall_ok[g]) begin
                  checks++;
                  if (cyc - fall_cyc[g] < GAP) begin
                     errors++;
                     $display("FAIL gap[%0d]: got %0d cycles after busy fell, required >= %0d", g, cyc - fall_cyc[g], GAP);
                  end
               end
            end
            if (req_ack[g] != 3'b000) begin
               checks++;
               if (ard[g] >= awr[g]) begin
                  errors++;
                  $display("FAIL ack_unexpected[%0d]: got %b, required no ack", g, req_ack[g]);
               end else begin
                  if (req_ack[g] !== aq[g][ard[g]]) begin
                     errors++;
                     $display("FAIL ack[%0d]#%0d: got %b, required %b", g, ard[g], req_ack[g], aq[g][ard[g]]);
                  end
                  ard[g]++;
               end
            end
         end
      end
   end

   initial begin
      int   n;
      logic seen;
      errors   = 0;
      checks   = 0;
      req_data = {D2, D1, D0};
      for (int g = 0; g < 2; g++) begin
         rst_n[g]      = 1'b0;
         req_valid[g]  = 3'b000;
         busy_m[g]     = 1'b0;
         busy_f[g]     = 1'b0;
         sen_en[g]     = 1'b1;
         lwr[g]        = 0;
         lrd[g]        = 0;
         awr[g]        = 0;
         ard[g]        = 0;
         launch_cyc[g] = 0;
         fall_cyc[g]   = 0;
         fall_ok[g]    = 1'b0;
      end
      repeat (3) @(posedge mon_clk);
      #1;
      check_reset(0);
      check_reset(1);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      repeat (2) @(posedge mon_clk);
      #1;

      // single request from source 1
      push_l(0, 2'd1, D1);
      push_a(0, 3'b010);
      req_valid[0] = 3'b010;
      expect_launch_next(0, "single_latency");
      wait_acks(0, 1);
      @(posedge mon_clk);
      #1 req_valid[0] = 3'b000;
      chk("single_grant_id", 64'(grant_id[0]), 64'd1);
      repeat (30) @(posedge mon_clk);
      #1;

      // foreign busy holds off the launch
      busy_f[0]    = 1'b1;
      req_valid[0] = 3'b001;
      push_l(0, 2'd0, D0);
      push_a(0, 3'b001);
      seen = 1'b0;
      repeat (6) begin
         @(negedge mon_clk);
         if (out_valid[0]) seen = 1'b1;
      end
      chk("foreign_hold", 64'(seen), 64'd0);
      @(posedge mon_clk);
      #1 busy_f[0] = 1'b0;
      expect_launch_next(0, "foreign_release");
      wait_acks(0, 2);
      @(posedge mon_clk);
      #1 req_valid[0] = 3'b000;
      repeat (30) @(posedge mon_clk);
      #1;

      // start timeout, then retry of the same requester
      sen_en[0] = 1'b0;
      push_l(0, 2'd2, D2);
      push_l(0, 2'd2, D2);
      push_a(0, 3'b100);
      req_valid[0] = 3'b100;
      n = 0;
      while (!timeout_err[0] && n < 60) begin
         @(negedge mon_clk);
         n++;
      end
      chk("timeout_seen", 64'(timeout_err[0]), 64'd1);
      chk("timeout_cycles", 64'(cyc - launch_cyc[0]), 64'(TMO + 1));
      chk("timeout_no_ack", 64'(ard[0]), 64'd2);
      sen_en[0] = 1'b1;
      wait_acks(0, 3);
      @(posedge mon_clk);
      #1 req_valid[0] = 3'b000;
      chk("timeout_sticky", 64'(timeout_err[0]), 64'd1);
      repeat (30) @(posedge mon_clk);
      #1;

      // asynchronous reset while the sender is busy
      push_l(0, 2'd1, D1);
      push_a(0, 3'b010);
      req_valid[0] = 3'b010;
      wait_acks(0, 4);
      @(posedge mon_clk);
      #1 req_valid[0] = 3'b000;
      repeat (2) @(posedge mon_clk);
      #3 rst_n[0] = 1'b0;
      #1 check_reset(0);
      n = 0;
      while (busy_m[0] && n < 60) begin
         @(posedge mon_clk);
         n++;
      end
      chk("reset_busy_drop", 64'(busy_m[0]), 64'd0);
      @(posedge mon_clk);
      #1 rst_n[0] = 1'b1;
      fall_ok[0] = 1'b0;

      // round-robin from a fresh pointer with all three held
      for (int k = 0; k < 6; k++) begin
         push_l(0, 2'(k % 3), (k % 3 == 0) ? D0 : (k % 3 == 1) ? D1 : D2);
         push_a(0, 3'b001 << (k % 3));
      end
      req_valid[0] = 3'b111;
      expect_launch_next(0, "post_reset_launch");
      wait_acks(0, 10);
      @(posedge mon_clk);
      #1 req_valid[0] = 3'b000;
      chk("terr_cleared_by_reset", 64'(timeout_err[0]), 64'd0);
      repeat (30) @(posedge mon_clk);
      #1;

      // urgent source 0 preempts round-robin
      push_l(1, 2'd1, D1);
      push_a(1, 3'b010);
      push_l(1, 2'd0, D0);
      push_a(1, 3'b001);
      push_l(1, 2'd2, D2);
      push_a(1, 3'b100);
      push_l(1, 2'd1, D1);
      push_a(1, 3'b010);
      req_valid[1] = 3'b110;
      wait_acks(1, 1);
      @(posedge mon_clk);
      #1 req_valid[1] = 3'b101;
      wait_acks(1, 2);
      @(posedge mon_clk);
      #1 req_valid[1] = 3'b100;
      wait_acks(1, 3);
      @(posedge mon_clk);
      #1 req_valid[1] = 3'b010;
      wait_acks(1, 4);
      @(posedge mon_clk);
      #1 req_valid[1] = 3'b000;
      repeat (30) @(posedge mon_clk);
      #1;

      for (int g = 0; g < 2; g++) begin
         chk("launch_drain", 64'(lrd[g]), 64'(lwr[g]));
         chk("ack_drain", 64'(ard[g]), 64'(awr[g]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
